mem_responder: RTL



---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_responder_if.sv | 20 ++
 rtl/mem_byte_array.sv | 38 +++
 rtl/mem_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: SPARC op3 codes, FSM states,
// access-size decoding.
package mem_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {BYTE, HALF, WORD, NONE} size_t;

    typedef struct packed {
        size_t size;
        logic  store;
        logic  sign;
    } dec_t;

    // Unsupported opcodes (LDD/STD included) decode to NONE: no write, zero data.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '{size: NONE, store: 1'b0, sign: 1'b0};
        case (op)
            OP_LD:   d = '{size: WORD, store: 1'b0, sign: 1'b0};
            OP_LDUB: d = '{size: BYTE, store: 1'b0, sign: 1'b0};
            OP_LDUH: d = '{size: HALF, store: 1'b0, sign: 1'b0};
            OP_ST:   d = '{size: WORD, store: 1'b1, sign: 1'b0};
            OP_STB:  d = '{size: BYTE, store: 1'b1, sign: 1'b0};
            OP_STH:  d = '{size: HALF, store: 1'b1, sign: 1'b0};
            OP_LDSB: d = '{size: BYTE, store: 1'b0, sign: 1'b1};
            OP_LDSH: d = '{size: HALF, store: 1'b0, sign: 1'b1};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store port between the datapath (master) and the memory responder (slave).
interface mem_responder_if;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] MAR_Out;
    logic [31:0] MDR_Out;
    logic [31:0] RAM_Out;
    logic        MFC;
    logic        MEM_Align_Err;

    modport master (
        output RAM_enable, RAM_OpCode, MAR_Out, MDR_Out,
        input  RAM_Out, MFC, MEM_Align_Err
    );

    modport slave (
        input  RAM_enable, RAM_OpCode, MAR_Out, MDR_Out,
        output RAM_Out, MFC, MEM_Align_Err
    );
endinterface

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four big-endian lanes: lane 0 (bits 31:24) is at addr,
// lane 3 (bits 7:0) at addr+3, all lane addresses wrapping modulo the depth.
module mem_byte_array #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr + ADDR_WIDTH'(i);
        end
    end

    // NOTE: storage arrays get no reset; clearing them would cost a write port
    // per entry, and software never relies on initial memory contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[3-i]) mem[lane_addr[i]] <= wdata[31-8*i -: 8];
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[31-8*i -: 8] = mem[lane_addr[i]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with wait states and a four-phase MFC handshake.
// Optional misalignment trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic            Clk,
    input  logic            Clr,
    mem_responder_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WAIT_STATES + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [31:0]           ram_out_q;
    logic                  mfc_q;
    logic                  err_q;

    logic [5:0]            cur_op;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [31:0]           cur_data;
    dec_t                  dec;
    logic                  blocked;
    logic                  commit;
    logic [3:0]            we;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic [31:0]           load_val;
    logic [31:0]           fin_ram_out;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.MAR_Out[31:ADDR_WIDTH];

    // In IDLE the live bus request is used so a zero-wait access can finish
    // on the same edge that accepts it.
    always_comb begin
        if (state == IDLE) begin
            cur_op   = bus.RAM_OpCode;
            cur_addr = bus.MAR_Out[ADDR_WIDTH-1:0];
            cur_data = bus.MDR_Out;
        end else begin
            cur_op   = op_q;
            cur_addr = addr_q;
            cur_data = data_q;
        end
    end

    assign dec = decode_op(cur_op);

`ifdef MEM_ALIGN_CHECK_EN
    assign blocked   = ((dec.size == HALF) && cur_addr[0]) ||
                       ((dec.size == WORD) && (cur_addr[1:0] != 2'b00));
    assign base_addr = cur_addr;
`else
    // Without the check, misalignment is forgiven by truncating the address.
    assign blocked = 1'b0;
    always_comb begin
        base_addr = cur_addr;
        case (dec.size)
            HALF:    base_addr[0]   = 1'b0;
            WORD:    base_addr[1:0] = 2'b00;
            default: ;
        endcase
    end
`endif

    assign commit = bus.RAM_enable &&
                    (((state == IDLE) && (WAIT_STATES == 0)) ||
                     ((state == BUSY) && (cnt == '0)));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        we    = 4'b0000;
        wdata = '0;
        if (commit && dec.store && !blocked) begin
            case (dec.size)
                BYTE:    begin we = 4'b1000; wdata = {cur_data[7:0], 24'h0};  end
                HALF:    begin we = 4'b1100; wdata = {cur_data[15:0], 16'h0}; end
                WORD:    begin we = 4'b1111; wdata = cur_data;                end
                default: ;
            endcase
        end
    end

    mem_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (Clk),
        .we    (we),
        .addr  (base_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        load_val = '0;
        case (dec.size)
            BYTE:    load_val = dec.sign ? {{24{rdata[31]}}, rdata[31:24]}
                                         : {24'h0, rdata[31:24]};
            HALF:    load_val = dec.sign ? {{16{rdata[31]}}, rdata[31:16]}
                                         : {16'h0, rdata[31:16]};
            WORD:    load_val = rdata;
            default: load_val = '0;
        endcase
    end

    // Stores and trapped accesses leave the previous load result in place.
    always_comb begin
        fin_ram_out = ram_out_q;
        if (!blocked && !dec.store) fin_ram_out = load_val;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ram_out_q <= '0;
            mfc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mfc_q <= 1'b0;
                    err_q <= 1'b0;
                    if (bus.RAM_enable) begin
                        op_q   <= bus.RAM_OpCode;
                        addr_q <= bus.MAR_Out[ADDR_WIDTH-1:0];
                        data_q <= bus.MDR_Out;
                        cnt    <= CNT_LOAD;
                        if (WAIT_STATES == 0) begin
                            state     <= DONE;
                            mfc_q     <= 1'b1;
                            err_q     <= blocked;
                            ram_out_q <= fin_ram_out;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.RAM_enable) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state     <= DONE;
                        mfc_q     <= 1'b1;
                        err_q     <= blocked;
                        ram_out_q <= fin_ram_out;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.RAM_enable) begin
                        state <= IDLE;
                        mfc_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RAM_Out       = ram_out_q;
    assign bus.MFC           = mfc_q;
    // blocked is constant 0 in the default build, so this is a tied-off zero there.
    assign bus.MEM_Align_Err = err_q;

endmodule
